// File: rtl/spw_char_pkg.sv
// rtl/spw_char_pkg.sv - character codes, NULL pattern, error indices and RX states
package spw_char_pkg;

    // Control codes in transmit order after the parity bit: {C, b1, b0}
    localparam logic [2:0] CODE_FCT = 3'b100;
    localparam logic [2:0] CODE_EOP = 3'b101;
    localparam logic [2:0] CODE_EEP = 3'b110;
    localparam logic [2:0] CODE_ESC = 3'b111;

    // NULL as seen in an 8-bit window, newest bit at LSB; the ESC parity bit is don't-care
    localparam logic [7:0] NULL_PATTERN = 8'b0111_0100;
    localparam logic [7:0] NULL_MASK    = 8'h7F;

    // N-char encodings presented on rx_data_out
    localparam logic [8:0] NCHAR_EOP = 9'h100;
    localparam logic [8:0] NCHAR_EEP = 9'h101;

    // Bit positions inside rx_error_type
    localparam int ERR_PARITY = 0;
    localparam int ERR_ESCAPE = 1;
    localparam int ERR_DISC   = 2;

    typedef enum logic [2:0] {
        RX_HUNT  = 3'b001,
        RX_RUN   = 3'b010,
        RX_ERROR = 3'b100
    } rx_state_t;

    function automatic logic null_match(input logic [7:0] window);
        return ((window ^ NULL_PATTERN) & NULL_MASK) == 8'h00;
    endfunction

endpackage

// File: rtl/rx_char_decoder_m_if.sv
// rtl/rx_char_decoder_m_if.sv - bit stream in, character events out
interface rx_char_decoder_m_if;

    logic       rx_bit;
    logic       rx_bit_valid;
    logic       rx_got_bit;
    logic       rx_got_null;
    logic       rx_got_fct;
    logic       rx_got_null_p;
    logic       rx_got_nchar;
    logic [8:0] rx_data_out;
    logic       rx_got_time_code;
    logic [7:0] rx_timecode_out;
    logic       rx_error;
    logic [2:0] rx_error_type;

    modport master (
        output rx_bit, rx_bit_valid,
        input  rx_got_bit, rx_got_null, rx_got_fct, rx_got_null_p, rx_got_nchar,
        input  rx_data_out, rx_got_time_code, rx_timecode_out, rx_error, rx_error_type
    );

    modport slave (
        input  rx_bit, rx_bit_valid,
        output rx_got_bit, rx_got_null, rx_got_fct, rx_got_null_p, rx_got_nchar,
        output rx_data_out, rx_got_time_code, rx_timecode_out, rx_error, rx_error_type
    );

endinterface

// File: rtl/rx_disconnect_timer_m.sv
// rtl/rx_disconnect_timer_m.sv - idle-cycle counter flagging a lost link
module rx_disconnect_timer_m #(
    parameter int unsigned DISC_CYCLES = 64
) (
    input  logic pclk_rx,
    input  logic enable_rx,
    input  logic rx_bit_valid,
    input  logic arm,
    output logic disconnect
);

    localparam logic [9:0] LAST = 10'(DISC_CYCLES - 1);

    logic [9:0] count;

    assign disconnect = arm && !rx_bit_valid && (count == LAST);

    // Count idle cycles while armed; any valid bit restarts the window
    always_ff @(posedge pclk_rx or negedge enable_rx) begin
        if (!enable_rx) begin
            count <= '0;
        end else if (!arm || rx_bit_valid) begin
            count <= '0;
        end else if (count != LAST) begin
            count <= count + 10'd1;
        end
    end

endmodule

// File: rtl/rx_char_decoder_m.sv
// rtl/rx_char_decoder_m.sv - NULL alignment, character decode and error detection
module rx_char_decoder_m
    import spw_char_pkg::*;
#(
    parameter int unsigned DISC_CYCLES = 64
) (
    input  logic               pclk_rx,
    input  logic               enable_rx,
    rx_char_decoder_m_if.slave bus
);

    rx_state_t  state, state_next;
    logic [7:0] shift_reg;
    logic [3:0] bit_cnt;
    logic       p_bit;
    logic       c_bit;
    logic [7:0] payload;
    logic       par_acc;
    logic       prev_par;
    logic       esc_pending;
    logic       disconnect;

    logic [7:0] hunt_window;
    logic       parity_fail;
    logic       char_done;
    logic [2:0] ctrl_code;
    logic [7:0] data_byte;
    logic       esc_error;

    // Character fields are derived from the stored bits plus the bit arriving now
    assign hunt_window = {shift_reg[6:0], bus.rx_bit};
    assign parity_fail = (bit_cnt == 4'd1) && !(p_bit ^ prev_par ^ bus.rx_bit);
    assign char_done   = c_bit ? (bit_cnt == 4'd3) : (bit_cnt == 4'd9);
    assign ctrl_code   = {1'b1, payload[7], bus.rx_bit};
    assign data_byte   = {bus.rx_bit, payload[7:1]};
    assign esc_error   = esc_pending && c_bit && (ctrl_code != CODE_FCT);

    rx_disconnect_timer_m #(.DISC_CYCLES(DISC_CYCLES)) u_timer (
        .pclk_rx      (pclk_rx),
        .enable_rx    (enable_rx),
        .rx_bit_valid (bus.rx_bit_valid),
        .arm          (bus.rx_got_bit && (state != RX_ERROR)),
        .disconnect   (disconnect)
    );

    // State register
    always_ff @(posedge pclk_rx or negedge enable_rx) begin
        if (!enable_rx) begin
            state <= RX_HUNT;
        end else begin
            state <= state_next;
        end
    end

    // Next state: align on NULL, drop into ERROR on any detected fault
    always_comb begin
        state_next = state;
        unique case (state)
            RX_HUNT: begin
                if (disconnect) begin
                    state_next = RX_ERROR;
                end else if (bus.rx_bit_valid && null_match(hunt_window)) begin
                    state_next = RX_RUN;
                end
            end
            RX_RUN: begin
                if (disconnect) begin
                    state_next = RX_ERROR;
                end else if (bus.rx_bit_valid && (parity_fail || (char_done && esc_error))) begin
                    state_next = RX_ERROR;
                end
            end
            RX_ERROR: state_next = RX_ERROR;
            default:  state_next = RX_HUNT;
        endcase
    end

    // Bit assembly, character decode, event pulses and sticky status
    always_ff @(posedge pclk_rx or negedge enable_rx) begin
        if (!enable_rx) begin
            shift_reg            <= '0;
            bit_cnt              <= '0;
            p_bit                <= 1'b0;
            c_bit                <= 1'b0;
            payload              <= '0;
            par_acc              <= 1'b0;
            prev_par             <= 1'b0;
            esc_pending          <= 1'b0;
            bus.rx_got_bit       <= 1'b0;
            bus.rx_got_null      <= 1'b0;
            bus.rx_got_fct       <= 1'b0;
            bus.rx_got_null_p    <= 1'b0;
            bus.rx_got_nchar     <= 1'b0;
            bus.rx_data_out      <= '0;
            bus.rx_got_time_code <= 1'b0;
            bus.rx_timecode_out  <= '0;
            bus.rx_error         <= 1'b0;
            bus.rx_error_type    <= '0;
        end else begin
            bus.rx_got_fct       <= 1'b0;
            bus.rx_got_null_p    <= 1'b0;
            bus.rx_got_nchar     <= 1'b0;
            bus.rx_got_time_code <= 1'b0;

            if (bus.rx_bit_valid) begin
                bus.rx_got_bit <= 1'b1;
            end
            if (state != RX_ERROR && state_next == RX_ERROR) begin
                bus.rx_error <= 1'b1;
            end
            if (disconnect) begin
                bus.rx_error_type[ERR_DISC] <= 1'b1;
            end

            if (state == RX_HUNT && bus.rx_bit_valid) begin
                shift_reg <= hunt_window;
                if (null_match(hunt_window)) begin
                    bus.rx_got_null <= 1'b1;
                    prev_par        <= 1'b0;
                    bit_cnt         <= '0;
                    esc_pending     <= 1'b0;
                end
            end

            if (state == RX_RUN && bus.rx_bit_valid) begin
                if (parity_fail) begin
                    bus.rx_error_type[ERR_PARITY] <= 1'b1;
                end else if (char_done) begin
                    bit_cnt  <= '0;
                    prev_par <= par_acc ^ bus.rx_bit;
                    if (c_bit) begin
                        if (esc_error) begin
                            bus.rx_error_type[ERR_ESCAPE] <= 1'b1;
                        end else if (esc_pending) begin
                            bus.rx_got_null_p <= 1'b1;
                            esc_pending       <= 1'b0;
                        end else begin
                            case (ctrl_code)
                                CODE_FCT: bus.rx_got_fct <= 1'b1;
                                CODE_EOP: begin
                                    bus.rx_data_out  <= NCHAR_EOP;
                                    bus.rx_got_nchar <= 1'b1;
                                end
                                CODE_EEP: begin
                                    bus.rx_data_out  <= NCHAR_EEP;
                                    bus.rx_got_nchar <= 1'b1;
                                end
                                default: esc_pending <= 1'b1;
                            endcase
                        end
                    end else if (esc_pending) begin
                        bus.rx_timecode_out  <= data_byte;
                        bus.rx_got_time_code <= 1'b1;
                        esc_pending          <= 1'b0;
                    end else begin
                        bus.rx_data_out  <= {1'b0, data_byte};
                        bus.rx_got_nchar <= 1'b1;
                    end
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                    if (bit_cnt == 4'd0) begin
                        p_bit   <= bus.rx_bit;
                        par_acc <= 1'b0;
                    end else if (bit_cnt == 4'd1) begin
                        c_bit <= bus.rx_bit;
                    end else begin
                        payload <= {bus.rx_bit, payload[7:1]};
                        par_acc <= par_acc ^ bus.rx_bit;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_rx_char_decoder_m.sv
// tb/tb_rx_char_decoder_m.sv - self-checking bench for rx_char_decoder_m
module tb_rx_char_decoder_m;

    localparam int DISC = 64;

    localparam int K_DATA = 0;
    localparam int K_FCT  = 1;
    localparam int K_EOP  = 2;
    localparam int K_EEP  = 3;
    localparam int K_ESC  = 4;

    logic pclk_rx   = 1'b0;
    logic enable_rx = 1'b0;

    rx_char_decoder_m_if bus();

    rx_char_decoder_m #(.DISC_CYCLES(DISC)) dut (
        .pclk_rx   (pclk_rx),
        .enable_rx (enable_rx),
        .bus       (bus)
    );

    always #5 pclk_rx = ~pclk_rx;

    int n_checks = 0;
    int n_fail   = 0;

    // Character-level reference state
    bit       m_prev_par;
    bit       m_esc;
    bit       m_err;
    bit [2:0] m_etype;
    bit [8:0] m_data;
    bit [7:0] m_tc;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    function automatic bit any_pulse();
        return bus.rx_got_fct | bus.rx_got_null_p | bus.rx_got_nchar | bus.rx_got_time_code;
    endfunction

    function automatic logic [26:0] all_outputs();
        return {bus.rx_got_bit, bus.rx_got_null, bus.rx_got_fct, bus.rx_got_null_p,
                bus.rx_got_nchar, bus.rx_data_out, bus.rx_got_time_code,
                bus.rx_timecode_out, bus.rx_error, bus.rx_error_type};
    endfunction

    task automatic model_reset();
        m_prev_par = 1'b0;
        m_esc      = 1'b0;
        m_err      = 1'b0;
        m_etype    = 3'b000;
        m_data     = 9'h000;
        m_tc       = 8'h00;
    endtask

    task automatic send_bit(input bit b);
        bus.rx_bit       = b;
        bus.rx_bit_valid = 1'b1;
        @(posedge pclk_rx);
        @(negedge pclk_rx);
        bus.rx_bit_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge pclk_rx);
            @(negedge pclk_rx);
        end
    endtask

    task automatic do_reset();
        enable_rx        = 1'b0;
        bus.rx_bit       = 1'b0;
        bus.rx_bit_valid = 1'b0;
        idle(2);
        enable_rx = 1'b1;
        idle(1);
        model_reset();
    endtask

    task automatic align(input int pre_zeros, input bit xbit);
        bit pat[8];
        pat = '{xbit, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        repeat (pre_zeros) send_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            send_bit(pat[i]);
            if (i == 6) begin
                n_checks++;
                if (bus.rx_got_null !== 1'b0) begin
                    n_fail++;
                    $display("FAIL early_null: got %b expected 0", bus.rx_got_null);
                end
            end
        end
        n_checks++;
        if ({bus.rx_got_null, any_pulse()} !== 2'b10) begin
            n_fail++;
            $display("FAIL align: got null=%b pulses=%b expected null=1 pulses=0",
                     bus.rx_got_null, any_pulse());
        end
        m_prev_par = 1'b0;
        m_esc      = 1'b0;
        idle(1);
    endtask

    // Encode one character from its definition, drive it, predict and check the result
    task automatic send_char(input int kind, input bit [7:0] val, input bit bad_par, input int max_gap);
        bit        bits[$];
        bit [7:0]  pay;
        int        np;
        bit        c;
        bit        ppar;
        bit        seen;
        bit        e_fct, e_nullp, e_nchar, e_tc;
        bit [24:0] exp_v;
        logic [24:0] obs_v;

        c = (kind != K_DATA);
        np = c ? 2 : 8;
        pay = 8'h00;
        case (kind)
            K_DATA: pay = val;
            K_FCT:  pay = 8'h00;
            K_EOP:  begin pay[0] = 1'b0; pay[1] = 1'b1; end
            K_EEP:  begin pay[0] = 1'b1; pay[1] = 1'b0; end
            default: begin pay[0] = 1'b1; pay[1] = 1'b1; end
        endcase
        ppar = 1'b0;
        for (int i = 0; i < np; i++) ppar = ppar ^ pay[i];

        bits.push_back(1'b1 ^ m_prev_par ^ c ^ bad_par);
        bits.push_back(c);
        for (int i = 0; i < np; i++) bits.push_back(pay[i]);

        seen = 1'b0;
        for (int i = 0; i < bits.size(); i++) begin
            send_bit(bits[i]);
            if (i != bits.size() - 1) begin
                seen = seen | any_pulse();
                repeat ($urandom_range(0, max_gap)) begin
                    idle(1);
                    seen = seen | any_pulse();
                end
            end
        end

        e_fct = 0; e_nullp = 0; e_nchar = 0; e_tc = 0;
        if (!m_err) begin
            if (bad_par) begin
                m_err = 1'b1;
                m_etype[0] = 1'b1;
            end else begin
                m_prev_par = ppar;
                if (m_esc) begin
                    m_esc = 1'b0;
                    if (kind == K_FCT) e_nullp = 1'b1;
                    else if (kind == K_DATA) begin
                        e_tc = 1'b1;
                        m_tc = val;
                    end else begin
                        m_err = 1'b1;
                        m_etype[1] = 1'b1;
                    end
                end else begin
                    case (kind)
                        K_DATA: begin e_nchar = 1'b1; m_data = {1'b0, val}; end
                        K_FCT:  e_fct = 1'b1;
                        K_EOP:  begin e_nchar = 1'b1; m_data = 9'h100; end
                        K_EEP:  begin e_nchar = 1'b1; m_data = 9'h101; end
                        default: m_esc = 1'b1;
                    endcase
                end
            end
        end

        exp_v = {e_fct, e_nullp, e_nchar, e_tc, m_data, m_tc, m_err, m_etype};
        obs_v = {bus.rx_got_fct, bus.rx_got_null_p, bus.rx_got_nchar, bus.rx_got_time_code,
                 bus.rx_data_out, bus.rx_timecode_out, bus.rx_error, bus.rx_error_type};
        n_checks++;
        if (obs_v !== exp_v) begin
            n_fail++;
            $display("FAIL char_k%0d_%h: got {fct,nullp,nchar,tc,data,tcout,err,etype}=%h expected %h",
                     kind, val, obs_v, exp_v);
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL early_pulse_k%0d: got %b expected 0", kind, seen);
        end
        idle(1);
        n_checks++;
        if (any_pulse() !== 1'b0) begin
            n_fail++;
            $display("FAIL pulse_width_k%0d: got %b expected 0", kind, any_pulse());
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (all_outputs() !== 27'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", all_outputs());
        end
    endtask

    task automatic test_align_fct();
        do_reset();
        align(2, 1'b0);
        send_char(K_FCT, 8'h00, 1'b0, 0);
    endtask

    task automatic test_data_eop_eep();
        do_reset();
        align(0, 1'b1);
        send_char(K_DATA, 8'hA5, 1'b0, 0);
        send_char(K_EOP, 8'h00, 1'b0, 0);
        send_char(K_EEP, 8'h00, 1'b0, 1);
    endtask

    task automatic test_time_code_null();
        do_reset();
        align(1, 1'b0);
        send_char(K_DATA, 8'h81, 1'b0, 0);
        send_char(K_ESC, 8'h00, 1'b0, 0);
        send_char(K_DATA, 8'h3C, 1'b0, 0);
        send_char(K_ESC, 8'h00, 1'b0, 0);
        send_char(K_FCT, 8'h00, 1'b0, 0);
        send_char(K_FCT, 8'h00, 1'b0, 0);
    endtask

    task automatic test_parity_error();
        do_reset();
        align(0, 1'b0);
        send_char(K_DATA, 8'h5A, 1'b0, 0);
        send_char(K_DATA, 8'($urandom_range(0, 255)), 1'b1, 0);
        send_char(K_FCT, 8'h00, 1'b0, 0);
        send_char(K_DATA, 8'h11, 1'b0, 1);
        enable_rx = 1'b0;
        #1;
        n_checks++;
        if (all_outputs() !== 27'd0) begin
            n_fail++;
            $display("FAIL error_reset: got %h expected 0", all_outputs());
        end
        do_reset();
        align(3, 1'b1);
        send_char(K_EOP, 8'h00, 1'b0, 0);
    endtask

    task automatic test_escape_error();
        int followers[3];
        followers = '{K_EOP, K_EEP, K_ESC};
        for (int i = 0; i < 3; i++) begin
            do_reset();
            align(0, 1'b0);
            send_char(K_ESC, 8'h00, 1'b0, 0);
            send_char(followers[i], 8'h00, 1'b0, 0);
            send_char(K_DATA, 8'h42, 1'b0, 0);
        end
    endtask

    task automatic check_disc(input string name, input logic [3:0] expected);
        n_checks++;
        if ({bus.rx_error, bus.rx_error_type} !== expected) begin
            n_fail++;
            $display("FAIL %s: got err=%b type=%b expected err=%b type=%b",
                     name, bus.rx_error, bus.rx_error_type, expected[3], expected[2:0]);
        end
    endtask

    task automatic test_disconnect();
        do_reset();
        send_bit(1'b0);
        n_checks++;
        if (bus.rx_got_bit !== 1'b1) begin
            n_fail++;
            $display("FAIL got_bit: got %b expected 1", bus.rx_got_bit);
        end
        idle(62);
        send_bit(1'b0);
        idle(1);
        check_disc("disc_rearm_64", 4'b0000);
        idle(62);
        check_disc("disc_hunt_63", 4'b0000);
        idle(1);
        check_disc("disc_hunt_64", 4'b1100);

        do_reset();
        align(0, 1'b0);
        send_char(K_DATA, 8'hC3, 1'b0, 0);
        idle(62);
        check_disc("disc_run_63", 4'b0000);
        idle(1);
        check_disc("disc_run_64", 4'b1100);
    endtask

    task automatic test_reset_mid_char();
        int n;
        do_reset();
        align(0, 1'b1);
        send_char(K_DATA, 8'h0F, 1'b0, 0);
        n = $urandom_range(1, 8);
        for (int i = 0; i < n; i++) send_bit(1'($urandom_range(0, 1)));
        enable_rx = 1'b0;
        #1;
        n_checks++;
        if (all_outputs() !== 27'd0) begin
            n_fail++;
            $display("FAIL mid_char_reset: got %h expected 0", all_outputs());
        end
        do_reset();
        align(2, 1'b0);
        send_char(K_DATA, 8'($urandom_range(0, 255)), 1'b0, 1);
    endtask

    task automatic test_random();
        int r;
        int kind;
        for (int round = 0; round < 6; round++) begin
            do_reset();
            align($urandom_range(0, 4), 1'($urandom_range(0, 1)));
            for (int k = 0; k < 30; k++) begin
                r = $urandom_range(0, 9);
                case (r)
                    4: kind = K_FCT;
                    5: kind = K_EOP;
                    6: kind = K_EEP;
                    7: kind = K_ESC;
                    default: kind = K_DATA;
                endcase
                send_char(kind, 8'($urandom_range(0, 255)), ($urandom_range(0, 39) == 0), 2);
            end
        end
    endtask

    initial begin
        bus.rx_bit       = 1'b0;
        bus.rx_bit_valid = 1'b0;
        model_reset();
        @(negedge pclk_rx);
        test_reset();
        test_align_fct();
        test_data_eop_eep();
        test_time_code_null();
        test_parity_error();
        test_escape_error();
        test_disconnect();
        test_reset_mid_char();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
